// File: rtl/bfm_apb_pkg.sv
// Shared encodings for the APB bus BFM family (bridge, decoders).
package bfm_apb_pkg;
  localparam int SLOT_W    = 4;
  localparam int ERR_RDATA = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/bfm_apb_bridge_param_if.sv
// Bus bundle for the APB bridge BFM: upstream completer side (_PM) and
// downstream requester side (_SC).
interface bfm_apb_bridge_param_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 16
);
  logic                    PSEL_PM;
  logic [ADDR_WIDTH-1:0]   PADDR_PM;
  logic                    PWRITE_PM;
  logic                    PENABLE_PM;
  logic [DATA_WIDTH-1:0]   PWDATA_PM;
  logic [DATA_WIDTH/8-1:0] PSTRB_PM;
  logic [2:0]              PPROT_PM;
  logic [DATA_WIDTH-1:0]   PRDATA_PM;
  logic                    PREADY_PM;
  logic                    PSLVERR_PM;

  logic [NUM_SLOTS-1:0]    PSEL_SC;
  logic [ADDR_WIDTH-1:0]   PADDR_SC;
  logic                    PWRITE_SC;
  logic                    PENABLE_SC;
  logic [DATA_WIDTH-1:0]   PWDATA_SC;
  logic [DATA_WIDTH/8-1:0] PSTRB_SC;
  logic [2:0]              PPROT_SC;
  logic [DATA_WIDTH-1:0]   PRDATA_SC;
  logic                    PREADY_SC;
  logic                    PSLVERR_SC;

  modport slave (
    input  PSEL_PM, PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM, PSTRB_PM, PPROT_PM,
           PRDATA_SC, PREADY_SC, PSLVERR_SC,
    output PRDATA_PM, PREADY_PM, PSLVERR_PM,
           PSEL_SC, PADDR_SC, PWRITE_SC, PENABLE_SC, PWDATA_SC, PSTRB_SC, PPROT_SC
  );

  modport master (
    output PSEL_PM, PADDR_PM, PWRITE_PM, PENABLE_PM, PWDATA_PM, PSTRB_PM, PPROT_PM,
           PRDATA_SC, PREADY_SC, PSLVERR_SC,
    input  PRDATA_PM, PREADY_PM, PSLVERR_PM,
           PSEL_SC, PADDR_SC, PWRITE_SC, PENABLE_SC, PWDATA_SC, PSTRB_SC, PPROT_SC
  );
endinterface

// File: rtl/bfm_apb_slot_decode.sv
// 4-bit slot field to one-hot select decoder; slots at or above NUM_SLOTS
// decode to no select and raise unmapped.
module bfm_apb_slot_decode
  import bfm_apb_pkg::*;
#(
  parameter int NUM_SLOTS = 16
) (
  input  logic [SLOT_W-1:0]    slot,
  output logic [NUM_SLOTS-1:0] onehot,
  output logic                 unmapped
);
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_hot
    assign onehot[i] = (slot == SLOT_W'(i));
  end

  assign unmapped = ~|onehot;
endmodule

// File: rtl/bfm_apb_bridge_param.sv
// Single-clock APB-to-APB bridge BFM: one upstream transfer at a time replayed on
// a slot-decoded downstream port, with unmapped-slot and PREADY-timeout errors.
module bfm_apb_bridge_param
  import bfm_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLOTS      = 16,
  parameter int SEL_LSB        = 24,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TPD            = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  bfm_apb_bridge_param_if.slave bus,
  output logic                  BUSY,
  output logic                  TIMEOUT_PULSE
);
  localparam int STRB_W = DATA_WIDTH/8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
    logic [2:0]            prot;
    logic                  write;
  } req_t;

  state_e               state, state_n;
  logic [15:0]          cnt, cnt_n;
  logic [NUM_SLOTS-1:0] sel_q, sel_n, sel_hot;
  logic                 en_q, en_n;
  req_t                 dn_q, dn_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic                 ready_q, ready_n, err_q, err_n;
  logic                 busy_q, tpulse_q, tpulse_n;
  logic                 unmapped;

  // This model is zero-delay; TPD is kept so timing-annotated wrappers share the parameter list.
  logic unused_tpd;
  assign unused_tpd = (TPD != 0);

  bfm_apb_slot_decode #(.NUM_SLOTS(NUM_SLOTS)) u_dec (
    .slot     (bus.PADDR_PM[SEL_LSB +: SLOT_W]),
    .onehot   (sel_hot),
    .unmapped (unmapped)
  );

  // Every output is computed for the next state and registered; the captured
  // request lives in the downstream field register while SETUP/ACCESS are active.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sel_n    = '0;
    en_n     = 1'b0;
    dn_n     = '0;
    rdata_n  = rdata_q;
    ready_n  = 1'b0;
    err_n    = 1'b0;
    tpulse_n = 1'b0;
    case (state)
      IDLE: begin
        if (bus.PSEL_PM && bus.PENABLE_PM) begin
          if (unmapped) begin
            state_n = RESP;
            ready_n = 1'b1;
            err_n   = 1'b1;
            rdata_n = DATA_WIDTH'(ERR_RDATA);
          end else begin
            state_n     = SETUP;
            sel_n       = sel_hot;
            dn_n.addr   = bus.PADDR_PM;
            dn_n.wdata  = bus.PWDATA_PM;
            dn_n.strb   = bus.PSTRB_PM;
            dn_n.prot   = bus.PPROT_PM;
            dn_n.write  = bus.PWRITE_PM;
          end
        end
      end
      SETUP: begin
        state_n = ACCESS;
        sel_n   = sel_q;
        en_n    = 1'b1;
        dn_n    = dn_q;
        cnt_n   = 16'd1;
      end
      ACCESS: begin
        if (bus.PREADY_SC) begin
          state_n = RESP;
          ready_n = 1'b1;
          err_n   = bus.PSLVERR_SC;
          rdata_n = dn_q.write ? '0 : bus.PRDATA_SC;
        end else if (TIMEOUT_CYCLES != 0 && cnt == 16'(TIMEOUT_CYCLES)) begin
          state_n  = RESP;
          ready_n  = 1'b1;
          err_n    = 1'b1;
          rdata_n  = DATA_WIDTH'(ERR_RDATA);
          tpulse_n = 1'b1;
        end else begin
          sel_n = sel_q;
          en_n  = 1'b1;
          dn_n  = dn_q;
          cnt_n = cnt + 16'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state    <= IDLE;
      cnt      <= '0;
      sel_q    <= '0;
      en_q     <= 1'b0;
      dn_q     <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      tpulse_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sel_q    <= sel_n;
      en_q     <= en_n;
      dn_q     <= dn_n;
      rdata_q  <= rdata_n;
      ready_q  <= ready_n;
      err_q    <= err_n;
      busy_q   <= (state_n != IDLE);
      tpulse_q <= tpulse_n;
    end
  end

  assign bus.PSEL_SC    = sel_q;
  assign bus.PENABLE_SC = en_q;
  assign bus.PADDR_SC   = dn_q.addr;
  assign bus.PWDATA_SC  = dn_q.wdata;
  assign bus.PSTRB_SC   = dn_q.strb;
  assign bus.PPROT_SC   = dn_q.prot;
  assign bus.PWRITE_SC  = dn_q.write;
  assign bus.PRDATA_PM  = rdata_q;
  assign bus.PREADY_PM  = ready_q;
  assign bus.PSLVERR_PM = err_q;
  assign BUSY           = busy_q;
  assign TIMEOUT_PULSE  = tpulse_q;
endmodule

// File: tb/tb_bfm_apb_bridge_param.sv
// Directed bench for the APB bridge BFM: dut_a (16 slots, timeout 8) and
// dut_b (4 slots) share one upstream driver; outputs are muxed by use_b.
module tb_bfm_apb_bridge_param;
  logic PCLK = 1'b0, PRESETN = 1'b0;
  always #5 PCLK = ~PCLK;

  logic        use_b = 1'b0;
  logic        psel = 1'b0, pen = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;

  int          dn_waits = 0, dn_cnt = 0;
  logic        dn_hang = 1'b0, dn_err = 1'b0;
  logic [31:0] dn_rdata = '0;

  logic        busy_a, tp_a, busy_b, tp_b;

  bfm_apb_bridge_param_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLOTS(16)) ifa ();
  bfm_apb_bridge_param_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLOTS(4))  ifb ();

  bfm_apb_bridge_param #(.NUM_SLOTS(16), .TIMEOUT_CYCLES(8)) dut_a (
    .PCLK(PCLK), .PRESETN(PRESETN), .bus(ifa), .BUSY(busy_a), .TIMEOUT_PULSE(tp_a));
  bfm_apb_bridge_param #(.NUM_SLOTS(4)) dut_b (
    .PCLK(PCLK), .PRESETN(PRESETN), .bus(ifb), .BUSY(busy_b), .TIMEOUT_PULSE(tp_b));

  assign ifa.PSEL_PM    = psel & ~use_b;
  assign ifa.PENABLE_PM = pen & ~use_b;
  assign ifa.PADDR_PM   = paddr;
  assign ifa.PWRITE_PM  = pwrite;
  assign ifa.PWDATA_PM  = pwdata;
  assign ifa.PSTRB_PM   = pstrb;
  assign ifa.PPROT_PM   = pprot;
  assign ifb.PSEL_PM    = psel & use_b;
  assign ifb.PENABLE_PM = pen & use_b;
  assign ifb.PADDR_PM   = paddr;
  assign ifb.PWRITE_PM  = pwrite;
  assign ifb.PWDATA_PM  = pwdata;
  assign ifb.PSTRB_PM   = pstrb;
  assign ifb.PPROT_PM   = pprot;

  // dn_cnt is the index of the current downstream access cycle (0 = first)
  always @(posedge PCLK) dn_cnt <= ifa.PENABLE_SC ? dn_cnt + 1 : 0;
  assign ifa.PREADY_SC  = ifa.PENABLE_SC & ~dn_hang & (dn_cnt == dn_waits);
  assign ifa.PRDATA_SC  = dn_rdata;
  assign ifa.PSLVERR_SC = dn_err;
  assign ifb.PREADY_SC  = ifb.PENABLE_SC;
  assign ifb.PRDATA_SC  = 32'h0BAD_BEEF;
  assign ifb.PSLVERR_SC = 1'b0;

  logic [15:0] m_sel;
  logic        m_en, m_wr, m_ready, m_err, m_busy, m_tp;
  logic [31:0] m_paddr, m_pwdata, m_rdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;
  assign m_sel    = use_b ? {12'b0, ifb.PSEL_SC} : ifa.PSEL_SC;
  assign m_en     = use_b ? ifb.PENABLE_SC : ifa.PENABLE_SC;
  assign m_wr     = use_b ? ifb.PWRITE_SC  : ifa.PWRITE_SC;
  assign m_paddr  = use_b ? ifb.PADDR_SC   : ifa.PADDR_SC;
  assign m_pwdata = use_b ? ifb.PWDATA_SC  : ifa.PWDATA_SC;
  assign m_strb   = use_b ? ifb.PSTRB_SC   : ifa.PSTRB_SC;
  assign m_prot   = use_b ? ifb.PPROT_SC   : ifa.PPROT_SC;
  assign m_ready  = use_b ? ifb.PREADY_PM  : ifa.PREADY_PM;
  assign m_err    = use_b ? ifb.PSLVERR_PM : ifa.PSLVERR_PM;
  assign m_rdata  = use_b ? ifb.PRDATA_PM  : ifa.PRDATA_PM;
  assign m_busy   = use_b ? busy_b : busy_a;
  assign m_tp     = use_b ? tp_b : tp_a;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          r_waits, r_en, r_setup, r_tp;
  logic [15:0] r_sel;
  logic [31:0] r_rdata;
  logic        r_err, r_busy, r_fld_ok, r_clean, r_done;

  // One upstream transfer; returns at the negedge where PREADY_PM is seen, so a
  // following call issues its setup phase in the cycle right after RESP.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input bit scr);
    @(posedge PCLK); #1;
    psel = 1'b1; pen = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge PCLK); #1;
    pen = 1'b1;
    r_waits = 0; r_en = 0; r_setup = 0; r_tp = 0; r_sel = '0; r_rdata = '0;
    r_err = 1'b0; r_busy = 1'b0; r_fld_ok = 1'b1; r_clean = 1'b1; r_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (m_sel != '0) begin
        if (m_paddr !== addr || m_pwdata !== wdata || m_wr !== wr ||
            m_strb !== strb || m_prot !== prot) r_fld_ok = 1'b0;
        if (!m_en) r_setup++;
      end else if (m_en || m_wr || m_paddr != '0 || m_pwdata != '0 || m_strb != '0 || m_prot != '0) begin
        r_clean = 1'b0;
      end
      if (!m_ready && m_err) r_clean = 1'b0;
      if (m_en) r_en++;
      if (m_tp) r_tp++;
      r_sel = r_sel | m_sel;
      if (m_ready) begin
        r_rdata = m_rdata; r_err = m_err; r_busy = m_busy; r_done = 1'b1;
        break;
      end
      r_waits++;
      if (scr && i == 1) begin
        paddr = ~addr; pwdata = ~wdata; pwrite = ~wr; pstrb = ~strb; pprot = ~prot;
      end
    end
    if (!r_done) chk("ready_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic expect_xfer(input string t, input int waits, input logic [15:0] sel, input int en,
                             input logic [31:0] rdata, input logic err, input int tp);
    chk({t, ".waits"},  r_waits, waits);
    chk({t, ".sel"},    r_sel, sel);
    chk({t, ".en"},     r_en, en);
    chk({t, ".setup"},  r_setup, (sel != '0) ? 1 : 0);
    chk({t, ".rdata"},  r_rdata, rdata);
    chk({t, ".err"},    r_err, err);
    chk({t, ".tpulse"}, r_tp, tp);
    chk({t, ".fields"}, r_fld_ok, 1);
    chk({t, ".clean"},  r_clean, 1);
    chk({t, ".busy"},   r_busy, 1);
  endtask

  task automatic idle_chk(input string t, input logic [31:0] rdata);
    @(posedge PCLK); #1;
    psel = 1'b0; pen = 1'b0;
    @(negedge PCLK);
    chk({t, ".ready"}, m_ready, 0);
    chk({t, ".hold"},  m_rdata, rdata);
    chk({t, ".busy"},  m_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst.sel",   m_sel, 0);
    chk("rst.ctl",   {m_en, m_ready, m_err, m_busy, m_tp}, 0);
    chk("rst.rdata", m_rdata, 0);
    chk("rst.paddr", m_paddr, 0);
    PRESETN = 1'b1;

    xfer(1'b1, 32'h0200_0010, 32'hA5A5_1234, 4'hF, 3'b000, 1'b0);
    expect_xfer("wr0", 3, 16'h0004, 1, 32'h0, 1'b0, 0);

    dn_waits = 3; dn_rdata = 32'hCAFE_F00D;
    xfer(1'b0, 32'h0500_0040, 32'h0000_0000, 4'h0, 3'b001, 1'b1);
    expect_xfer("rd5", 6, 16'h0020, 4, 32'hCAFE_F00D, 1'b0, 0);
    idle_chk("rd5_idle", 32'hCAFE_F00D);

    dn_hang = 1'b1;
    xfer(1'b0, 32'h0700_0000, 32'h0, 4'h0, 3'b000, 1'b0);
    expect_xfer("tmo", 10, 16'h0080, 8, 32'h0, 1'b1, 1);
    idle_chk("tmo_idle", 32'h0);

    dn_hang = 1'b0; dn_waits = 0; dn_err = 1'b1;
    xfer(1'b1, 32'h0300_0008, 32'h0F0F_0F0F, 4'b0101, 3'b010, 1'b0);
    expect_xfer("slverr", 3, 16'h0008, 1, 32'h0, 1'b1, 0);
    dn_err = 1'b0;

    dn_waits = 7; dn_rdata = 32'h1234_5678;
    xfer(1'b0, 32'h0100_0004, 32'h0, 4'h0, 3'b000, 1'b0);
    expect_xfer("rdy8", 10, 16'h0002, 8, 32'h1234_5678, 1'b0, 0);
    idle_chk("rdy8_idle", 32'h1234_5678);

    // reset asserted in the second downstream access cycle
    dn_hang = 1'b1; dn_waits = 0;
    @(posedge PCLK); #1;
    psel = 1'b1; pen = 1'b0; pwrite = 1'b0; paddr = 32'h0200_0000;
    @(posedge PCLK); #1;
    pen = 1'b1;
    @(posedge PCLK);
    @(posedge PCLK);
    @(posedge PCLK); #1;
    chk("rstmid.pre_en", m_en, 1);
    #2;
    PRESETN = 1'b0;
    #1;
    chk("rstmid.sel",   m_sel, 0);
    chk("rstmid.ctl",   {m_en, m_ready, m_err, m_busy, m_tp}, 0);
    chk("rstmid.paddr", m_paddr, 0);
    chk("rstmid.rdata", m_rdata, 0);
    psel = 1'b0; pen = 1'b0; dn_hang = 1'b0;
    @(negedge PCLK);
    PRESETN = 1'b1;

    xfer(1'b1, 32'h0200_0020, 32'h5555_AAAA, 4'hF, 3'b100, 1'b0);
    expect_xfer("post_rst", 3, 16'h0004, 1, 32'h0, 1'b0, 0);
    idle_chk("post_rst_idle", 32'h0);

    use_b = 1'b1;
    xfer(1'b0, 32'h0300_0000, 32'h0, 4'h0, 3'b000, 1'b0);
    expect_xfer("b_rd3", 3, 16'h0008, 1, 32'h0BAD_BEEF, 1'b0, 0);
    xfer(1'b0, 32'h0900_0000, 32'h0, 4'h0, 3'b000, 1'b0);
    expect_xfer("b_unmap", 1, 16'h0000, 0, 32'h0, 1'b1, 0);
    idle_chk("b_idle", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
